// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and op-decode helpers for the RV32M multiply/divide unit
// Contents: sequencer state codes, RV32M funct3 codes, and op-classification functions
//           used by both the sequencer FSM and the datapath.
package muldiv_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   function automatic logic is_div(input logic [2:0] f3);
      case (f3)
         F3_DIV, F3_DIVU, F3_REM, F3_REMU: return 1'b1;
         default:                          return 1'b0;
      endcase
   endfunction

   function automatic logic is_rem(input logic [2:0] f3);
      return (f3 == F3_REM) || (f3 == F3_REMU);
   endfunction

   function automatic logic is_mul_high(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_MULHU);
   endfunction

   function automatic logic op_signed_a(input logic [2:0] f3);
      case (f3)
         F3_MULH, F3_MULHSU, F3_DIV, F3_REM: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic op_signed_b(input logic [2:0] f3);
      case (f3)
         F3_MULH, F3_DIV, F3_REM: return 1'b1;
         default:                 return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/module_muldiv_datapath.sv
// rtl/module_muldiv_datapath.sv - operand, accumulator and result registers for the iterative mul/div
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   load_op                 latch funct3, |A|/|B| (or raw), sign of result; clear accumulator
//   step                    one radix-2 shift-add (mul) or restoring shift-subtract (div) iteration
//   load_fix                load the sign-corrected, selected result into the result register
//   load_fast               load the divide-by-zero / overflow result into the result register
//   funct3, rs1, rs2        op code and operands from EX
//   fast                    current inputs describe a divide fast-path case
//   result                  registered result
module module_muldiv_datapath
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_op,
   input  logic            step,
   input  logic            load_fix,
   input  logic            load_fast,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            fast,
   output logic [XLEN-1:0] result
);

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [2:0]      f3_q;
   logic            neg_q;
   // hi_q: product high half / remainder; lo_q: multiplier+product low half / dividend+quotient
   logic [XLEN-1:0] hi_q, lo_q, b_q, result_q;

   logic            a_sign, b_sign, neg_d;
   logic [XLEN-1:0] a_abs, b_abs;

   assign a_sign = op_signed_a(funct3) & rs1[XLEN-1];
   assign b_sign = op_signed_b(funct3) & rs2[XLEN-1];
   assign a_abs  = a_sign ? -rs1 : rs1;
   assign b_abs  = b_sign ? -rs2 : rs2;
   // A remainder takes the dividend's sign; products and quotients take the xor.
   assign neg_d  = is_rem(funct3) ? a_sign : (a_sign ^ b_sign);

   logic            div_zero, div_ovf;
   logic [XLEN-1:0] fast_res;

   assign div_zero = (rs2 == '0);
   assign div_ovf  = op_signed_a(funct3) & (rs1 == MIN_NEG) & (rs2 == '1);
   assign fast     = is_div(funct3) & (div_zero | div_ovf);

   always_comb begin
      fast_res = '0;
      if (div_zero) fast_res = is_rem(funct3) ? rs1 : '1;
      else          fast_res = is_rem(funct3) ? '0  : MIN_NEG;
   end

   logic [XLEN:0]   mul_sum, div_shift;
   logic [XLEN-1:0] div_sub;
   logic            div_ge;

   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
   assign div_shift = {hi_q, lo_q[XLEN-1]};
   assign div_ge    = (div_shift >= {1'b0, b_q});
   // The partial remainder stays below the divisor, so the true difference fits in XLEN bits.
   assign div_sub   = div_shift[XLEN-1:0] - b_q;

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   qr_sel, qr_fix, fix_res;

   // High-word results need the full 64-bit negate so borrows from the low half propagate.
   assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
   assign qr_sel   = is_rem(f3_q) ? hi_q : lo_q;
   assign qr_fix   = neg_q ? -qr_sel : qr_sel;
   assign fix_res  = is_div(f3_q)      ? qr_fix :
                     is_mul_high(f3_q) ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f3_q  <= F3_MUL;
         neg_q <= 1'b0;
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
      end else if (load_op) begin
         f3_q  <= funct3;
         neg_q <= neg_d;
         hi_q  <= '0;
         lo_q  <= a_abs;
         b_q   <= b_abs;
      end else if (step) begin
         if (is_div(f3_q)) begin
            hi_q <= div_ge ? div_sub : div_shift[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], div_ge};
         end else begin
            hi_q <= mul_sum[XLEN:1];
            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         result_q <= '0;
      else if (load_fix)  result_q <= fix_res;
      else if (load_fast) result_q <= fast_res;
   end

   assign result = result_q;

endmodule

// File: rtl/module_muldiv_sequencer.sv
// rtl/module_muldiv_sequencer.sv - RV32M iterative multiply/divide unit with its own sequencer FSM
// Ports:
//   clk_i, rst_n_i          core clock, asynchronous active-low reset
//   start_i                 EX holds a valid M-op
//   funct3_i                RV32M op select
//   rs1_i, rs2_i            operand A / dividend, operand B / divisor
//   flush_i                 EX flush; abandons any op in flight
//   busy_o                  unit not idle
//   stall_o                 hold IF/ID/EX pipeline registers
//   done_o                  one-cycle pulse, result_o valid
//   result_o                result, held until the next done
module module_muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int              CNT_W    = $clog2(XLEN) + 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             accept, fast;

   assign accept = (state_q == S_IDLE) & start_i & ~flush_i;

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (start_i) state_d = fast ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == 1) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept)
            cnt_q <= CNT_INIT;
         else if (state_q == S_CALC && !flush_i)
            cnt_q <= cnt_q - 1'b1;
      end
   end

   module_muldiv_datapath #(
      .XLEN      (XLEN)
   ) u_datapath (
      .clk       (clk_i),
      .rst_n     (rst_n_i),
      .load_op   (accept & ~fast),
      .step      ((state_q == S_CALC) & ~flush_i),
      .load_fix  ((state_q == S_FIX) & ~flush_i),
      .load_fast (accept & fast),
      .funct3    (funct3_i),
      .rs1       (rs1_i),
      .rs2       (rs2_i),
      .fast      (fast),
      .result    (result_o)
   );

   assign busy_o  = (state_q != S_IDLE);
   assign done_o  = (state_q == S_DONE);
   // Stall is released in DONE so EX captures result_o and advances in that same cycle.
   assign stall_o = (state_q == S_CALC) | (state_q == S_FIX) | accept;

endmodule

// File: tb/tb_module_muldiv_sequencer.sv
// tb/tb_module_muldiv_sequencer.sv - directed scoreboard bench for module_muldiv_sequencer
module tb_module_muldiv_sequencer;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, start, flush;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2;
   logic        busy, stall, done;
   logic [31:0] result;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] sb[$];
   logic [31:0] last_res = '0;

   always #5 clk = ~clk;

   module_muldiv_sequencer #(.XLEN(32)) dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .start_i  (start),
      .funct3_i (funct3),
      .rs1_i    (rs1),
      .rs2_i    (rs2),
      .flush_i  (flush),
      .busy_o   (busy),
      .stall_o  (stall),
      .done_o   (done),
      .result_o (result)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the unit idle: this cycle is t0. Returns at the negedge of t0+1.
   task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit push);
      funct3 = f3; rs1 = a; rs2 = b; start = 1'b1;
      if (push) sb.push_back(exp);
      #1;
      chk({tag, " t0 stall"}, {31'b0, stall}, 32'd1);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Entered at the negedge of t0+1; returns at the negedge of the done cycle.
   task automatic wait_done(input string tag, input int lat);
      int          cyc = 1;
      bit          gap = 1'b0;
      logic [31:0] exp;
      while (done !== 1'b1 && cyc <= 60) begin
         if (stall !== 1'b1) gap = 1'b1;
         @(negedge clk);
         cyc++;
      end
      chk({tag, " done seen"}, {31'b0, done}, 32'd1);
      chk({tag, " latency"}, cyc, lat);
      chk({tag, " stall before done"}, {31'b0, gap}, 32'd0);
      chk({tag, " stall in done"}, {31'b0, stall}, 32'd0);
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      chk({tag, " result"}, result, exp);
      last_res = exp;
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      issue(tag, f3, a, b, exp, 1'b1);
      wait_done(tag, lat);
      @(negedge clk);
      chk({tag, " idle busy"}, {31'b0, busy}, 32'd0);
      chk({tag, " idle done"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      bit seen_done;
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset busy",   {31'b0, busy},  32'd0);
      chk("reset stall",  {31'b0, stall}, 32'd0);
      chk("reset done",   {31'b0, done},  32'd0);
      chk("reset result", result,         32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("mul",        F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      run_op("mulh",       F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      run_op("mulhu",      F3_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      run_op("mulhsu",     F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
      run_op("div neg",    F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
      run_op("rem neg",    F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
      run_op("div negb",   F3_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
      run_op("rem negb",   F3_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         34);
      run_op("divu",       F3_DIVU,   32'd100,       32'd7,         32'd14,        34);
      run_op("remu",       F3_REMU,   32'd100,       32'd7,         32'd2,         34);
      run_op("divu by0",   F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run_op("rem by0",    F3_REM,    32'd5,         32'd0,         32'd5,         1);
      run_op("div ovf",    F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem ovf",    F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
      run_op("mul by0",    F3_MUL,    32'd5,         32'd0,         32'd0,         34);

      // Flush during a multiply: no done, result held, then a fresh divide.
      issue("flush mul", F3_MUL, 32'd3, 32'd5, 32'd0, 1'b0);
      seen_done = 1'b0;
      repeat (9) begin
         if (done === 1'b1) seen_done = 1'b1;
         @(negedge clk);
      end
      flush = 1'b1;
      start = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      start = 1'b0;
      #1;
      chk("flush busy",   {31'b0, busy},  32'd0);
      chk("flush stall",  {31'b0, stall}, 32'd0);
      chk("flush nodone", {31'b0, (seen_done | done)}, 32'd0);
      chk("flush result", result, last_res);
      run_op("divu post flush", F3_DIVU, 32'd9, 32'd3, 32'd3, 34);

      // Reset in the middle of a divide.
      issue("rst div", F3_DIV, 32'd1000, 32'd7, 32'd0, 1'b0);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst busy",   {31'b0, busy},  32'd0);
      chk("midrst stall",  {31'b0, stall}, 32'd0);
      chk("midrst done",   {31'b0, done},  32'd0);
      chk("midrst result", result,         32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      last_res = '0;
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) seen_done = 1'b1;
      end
      chk("midrst no done", {31'b0, seen_done}, 32'd0);

      // Back-to-back: second op presented during DONE, accepted in the following IDLE cycle.
      issue("b2b first", F3_MUL, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b1);
      wait_done("b2b first", 34);
      funct3 = F3_DIV; rs1 = 32'd7; rs2 = 32'hFFFF_FFFE; start = 1'b1;
      #1;
      chk("b2b done stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      chk("b2b idle busy", {31'b0, busy}, 32'd0);
      issue("b2b second", F3_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1);
      wait_done("b2b second", 34);
      @(negedge clk);
      chk("b2b end busy", {31'b0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
